// File: rtl/clk_meter_pkg.sv
// Shared types and sizing helpers for the multi-channel period meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SKIP   = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } chan_state_e;

  function automatic int acc_width(input int cnt_w, input int avg_log2);
    return cnt_w + avg_log2;
  endfunction

  function automatic longint unsigned tmo_limit(input int cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    if (a > b) begin
      return a - b;
    end else begin
      return b - a;
    end
  endfunction

endpackage

// File: rtl/clk_meter_chan.sv
// One measurement channel: synchroniser, edge detector, skip/average FSM and timeout.
// Optional stability check is compiled in with CLK_METER_STABLE_EN.
module clk_meter_chan
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SKIP_EDGES  = 3,
  parameter int AVG_LOG2    = 2
`ifdef CLK_METER_STABLE_EN
  , parameter int TOL       = 1
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sig,
  output logic             active,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] period
`ifdef CLK_METER_STABLE_EN
  , output logic           stable
`endif
);

  localparam int ACC_W  = acc_width(CNT_W, AVG_LOG2);
  localparam int AVG_N  = 1 << AVG_LOG2;
  localparam int ECNT_W = $clog2(((SKIP_EDGES > AVG_N) ? SKIP_EDGES : AVG_N) + 1);
  localparam int MEAN_W = CNT_W + 1;
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(tmo_limit(CNT_W) - 64'd1);
  localparam logic [CNT_W-1:0]  TMO_ONE   = CNT_W'(1);
  localparam logic [ECNT_W-1:0] SKIP_LAST = ECNT_W'(SKIP_EDGES);
  localparam logic [ECNT_W-1:0] AVG_LAST  = ECNT_W'(AVG_N - 1);
  localparam logic [ECNT_W-1:0] ECNT_ONE  = ECNT_W'(1);
  localparam logic [ACC_W-1:0]  ACC_ONE   = ACC_W'(1);
  localparam logic [ACC_W:0]    TOTAL_ONE = (ACC_W + 1)'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   edge_s;
  chan_state_e            state_r, state_nx_s;
  logic [ECNT_W-1:0]      edge_cnt_r, edge_cnt_nx_s;
  logic [ACC_W-1:0]       acc_r, acc_nx_s;
  logic [ACC_W:0]         total_r, total_nx_s;
  logic [CNT_W-1:0]       tmo_r, tmo_nx_s;
  logic [MEAN_W-1:0]      mean_s;
  logic                   valid_r, valid_nx_s;
  logic                   timeout_r, timeout_nx_s;
  logic [CNT_W-1:0]       period_r, period_nx_s;
`ifdef CLK_METER_STABLE_EN
  logic                   stable_r, stable_nx_s;
  logic [CNT_W-1:0]       prev_period_r, prev_period_nx_s;
  logic                   prev_ok_r, prev_ok_nx_s;
`endif

  // The extra top bit of mean_s flags a mean that cannot be represented in CNT_W bits.
  assign mean_s = MEAN_W'(total_r >> AVG_LOG2);
  assign edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign active = (state_r == SKIP) || (state_r == COUNT);

  // Synchroniser chain plus history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sig};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Channel state, counters and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      edge_cnt_r    <= '0;
      acc_r         <= '0;
      total_r       <= '0;
      tmo_r         <= '0;
      valid_r       <= 1'b0;
      timeout_r     <= 1'b0;
      period_r      <= '0;
`ifdef CLK_METER_STABLE_EN
      stable_r      <= 1'b0;
      prev_period_r <= '0;
      prev_ok_r     <= 1'b0;
`endif
    end else begin
      state_r       <= state_nx_s;
      edge_cnt_r    <= edge_cnt_nx_s;
      acc_r         <= acc_nx_s;
      total_r       <= total_nx_s;
      tmo_r         <= tmo_nx_s;
      valid_r       <= valid_nx_s;
      timeout_r     <= timeout_nx_s;
      period_r      <= period_nx_s;
`ifdef CLK_METER_STABLE_EN
      stable_r      <= stable_nx_s;
      prev_period_r <= prev_period_nx_s;
      prev_ok_r     <= prev_ok_nx_s;
`endif
    end
  end

  // Next-state and datapath updates for the skip / count / report sequence.
  always_comb begin
    state_nx_s       = state_r;
    edge_cnt_nx_s    = edge_cnt_r;
    acc_nx_s         = acc_r;
    total_nx_s       = total_r;
    tmo_nx_s         = tmo_r;
    valid_nx_s       = valid_r;
    timeout_nx_s     = timeout_r;
    period_nx_s      = period_r;
`ifdef CLK_METER_STABLE_EN
    stable_nx_s      = stable_r;
    prev_period_nx_s = prev_period_r;
    prev_ok_nx_s     = prev_ok_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s    = SKIP;
          edge_cnt_nx_s = '0;
          tmo_nx_s      = '0;
          valid_nx_s    = 1'b0;
          timeout_nx_s  = 1'b0;
`ifdef CLK_METER_STABLE_EN
          stable_nx_s   = 1'b0;
`endif
        end else begin
          state_nx_s = IDLE;
        end
      end
      SKIP: begin
        if (edge_s) begin
          tmo_nx_s = '0;
          if (edge_cnt_r == SKIP_LAST) begin
            state_nx_s    = COUNT;
            acc_nx_s      = '0;
            edge_cnt_nx_s = '0;
          end else begin
            edge_cnt_nx_s = edge_cnt_r + ECNT_ONE;
          end
        end else if (tmo_r == TMO_LAST) begin
          state_nx_s    = IDLE;
          timeout_nx_s  = 1'b1;
          period_nx_s   = '1;
          valid_nx_s    = 1'b0;
`ifdef CLK_METER_STABLE_EN
          stable_nx_s   = 1'b0;
          prev_ok_nx_s  = 1'b0;
`endif
        end else begin
          tmo_nx_s = tmo_r + TMO_ONE;
        end
      end
      COUNT: begin
        acc_nx_s = acc_r + ACC_ONE;
        if (edge_s) begin
          tmo_nx_s = '0;
          if (edge_cnt_r == AVG_LAST) begin
            state_nx_s = REPORT;
            total_nx_s = {1'b0, acc_r} + TOTAL_ONE;
          end else begin
            edge_cnt_nx_s = edge_cnt_r + ECNT_ONE;
          end
        end else if (tmo_r == TMO_LAST) begin
          state_nx_s    = IDLE;
          timeout_nx_s  = 1'b1;
          period_nx_s   = '1;
          valid_nx_s    = 1'b0;
`ifdef CLK_METER_STABLE_EN
          stable_nx_s   = 1'b0;
          prev_ok_nx_s  = 1'b0;
`endif
        end else begin
          tmo_nx_s = tmo_r + TMO_ONE;
        end
      end
      REPORT: begin
        state_nx_s = IDLE;
        if (mean_s[CNT_W]) begin
          period_nx_s  = '1;
          timeout_nx_s = 1'b1;
          valid_nx_s   = 1'b0;
`ifdef CLK_METER_STABLE_EN
          stable_nx_s  = 1'b0;
          prev_ok_nx_s = 1'b0;
`endif
        end else begin
          period_nx_s      = mean_s[CNT_W-1:0];
          valid_nx_s       = 1'b1;
`ifdef CLK_METER_STABLE_EN
          stable_nx_s      = prev_ok_r &&
                             (abs_diff(32'(mean_s[CNT_W-1:0]), 32'(prev_period_r)) <= 32'(TOL));
          prev_period_nx_s = mean_s[CNT_W-1:0];
          prev_ok_nx_s     = 1'b1;
`endif
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  assign valid   = valid_r;
  assign timeout = timeout_r;
  assign period  = period_r;
`ifdef CLK_METER_STABLE_EN
  assign stable  = stable_r;
`endif

endmodule

// File: rtl/clk_period_meter.sv
// Multi-channel period meter top: per-channel instances, BUSY/DONE aggregation, PERIOD packing.
// Optional STABLE output is present only with CLK_METER_STABLE_EN.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SKIP_EDGES  = 3,
  parameter int AVG_LOG2    = 2,
  parameter int TOL         = 1
) (
  input  logic                    CLK_IN,
  input  logic                    RESET,
  input  logic                    START,
  input  logic [NUM_CH-1:0]       SIG_IN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [NUM_CH-1:0]       VALID,
  output logic [NUM_CH-1:0]       TIMEOUT,
  output logic [NUM_CH*CNT_W-1:0] PERIOD
`ifdef CLK_METER_STABLE_EN
  , output logic [NUM_CH-1:0]     STABLE
`endif
);

  logic              busy_r;
  logic              done_r;
  logic              start_s;
  logic [NUM_CH-1:0] active_s;

  // A START arriving while any channel is still measuring is dropped for every channel.
  assign start_s = START & ~busy_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_chan
    clk_meter_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .SKIP_EDGES  (SKIP_EDGES),
      .AVG_LOG2    (AVG_LOG2)
`ifdef CLK_METER_STABLE_EN
      , .TOL       (TOL)
`endif
    ) u_chan (
      .clk     (CLK_IN),
      .reset   (RESET),
      .start   (start_s),
      .sig     (SIG_IN[i]),
      .active  (active_s[i]),
      .valid   (VALID[i]),
      .timeout (TIMEOUT[i]),
      .period  (PERIOD[i*CNT_W +: CNT_W])
`ifdef CLK_METER_STABLE_EN
      , .stable(STABLE[i])
`endif
    );
  end

  // Registered activity flag and its falling-edge pulse.
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= |active_s;
      done_r <= busy_r & ~(|active_s);
    end
  end

  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Synthesizable multi-channel period meter. It measures the period of NUM_CH slow, asynchronous signals in cycles of CLK_IN.
- Typical measured signals: divided MMCM outputs, heartbeat strobes, external reference ticks.
- It is the hardware counterpart of the bench-side frequency check: it skips settling edges, then averages 2^AVG_LOG2 periods per channel.
- Sits beside the clock manager and reports results to a status register block.

Parameters:
NUM_CH, 4, number of measured channels
CNT_W, 16, width of the reported period and of the timeout limit
SYNC_STAGES, 2, synchroniser depth per SIG_IN bit (minimum 2)
SKIP_EDGES, 3, rising edges ignored after START before measurement begins
AVG_LOG2, 2, measure 2^AVG_LOG2 consecutive periods and report their mean
TOL, 1, stability tolerance in cycles (used only with the optional feature)

Ports:
CLK_IN  input  1  sole clock
RESET  input  1  synchronous, active-high reset
START  input  1  one-cycle pulse; begins a measurement on all channels
SIG_IN  input  NUM_CH  asynchronous signals to be measured
BUSY  output  1  high while any channel is in SKIP or COUNT
DONE  output  1  one-cycle pulse when the last channel leaves COUNT/SKIP
VALID  output  NUM_CH  per-channel result valid
TIMEOUT  output  NUM_CH  per-channel no-edge timeout
PERIOD  output  NUM_CH*CNT_W  channel i at bits [i*CNT_W +: CNT_W]; mean period in cycles
STABLE  output  NUM_CH  exists only with CLK_METER_STABLE_EN

Behaviour:
- Reset (synchronous, active-high; applies mid-operation too):
  - all channels return to IDLE; synchronisers cleared.
  - BUSY=0, DONE=0, VALID=0, TIMEOUT=0, PERIOD=0, STABLE=0.
- Edge detection:
  - SIG_IN[i] passes through SYNC_STAGES flops plus one history flop.
  - edge = sync & ~prev, a one-cycle pulse. Detection latency is SYNC_STAGES+1 cycles, which is constant and does not affect the measured period.
  - Pulses narrower than one CLK_IN period may be missed; this is not a supported case.
- Per-channel FSM states: IDLE, SKIP, COUNT, REPORT.
  - IDLE: START clears VALID, TIMEOUT and STABLE (PERIOD holds) and moves to SKIP with edge_cnt=0 and tmo=0.
  - SKIP: each edge increments edge_cnt. On edge number SKIP_EDGES+1: acc<=0, edge_cnt<=0, go to COUNT. If SKIP_EDGES=0, the first edge starts COUNT.
  - COUNT: acc increments every cycle. On each edge, edge_cnt increments. On the edge where edge_cnt reaches 2^AVG_LOG2, total = acc+1 and the FSM goes to REPORT.
  - REPORT (one cycle):
    - PERIOD[i] <= total >> AVG_LOG2 (truncating), VALID[i] <= 1, then IDLE.
    - If total >> AVG_LOG2 exceeds 2^CNT_W-1, instead PERIOD = all ones and TIMEOUT=1.
- Accumulator width: acc is CNT_W+AVG_LOG2 bits and must not wrap.
- Timeout:
  - tmo counts cycles since the last edge (or since START) while in SKIP or COUNT; any edge clears it.
  - When tmo reaches 2^CNT_W-1: TIMEOUT[i]=1, PERIOD[i]=all ones, VALID[i]=0, state IDLE.
- START handling:
  - START while BUSY=1 is ignored entirely; no restart.
  - START in the same cycle as a channel's REPORT is ignored for that channel.
- BUSY and DONE:
  - BUSY is the registered OR of (state in SKIP or COUNT) over all channels.
  - DONE pulses exactly one cycle, on the cycle BUSY falls 1→0.
- Channels are fully independent; simultaneous edges on all channels are legal.

Optional Feature:
- Macro: CLK_METER_STABLE_EN.
- With the macro defined:
  - each channel keeps its previous PERIOD.
  - In REPORT, STABLE[i] <= (VALID was already 1 from an earlier run) && |new - prev| <= TOL. START does not clear the stored previous value, but clears STABLE.
  - TIMEOUT forces STABLE=0 and invalidates the stored previous value.
- Without the macro: the STABLE port, the stored previous value and the comparator are absent.

Decomposition:
- Package clk_meter_pkg holds:
  - the channel state enum (IDLE, SKIP, COUNT, REPORT).
  - constant functions for the accumulator width (CNT_W+AVG_LOG2) and the timeout limit.
- Sub-module clk_meter_chan:
  - contains one channel: synchroniser, edge detector, FSM, acc/tmo counters, optional stability check.
  - instantiated NUM_CH times in a generate loop.
- The top level holds only the BUSY/DONE aggregation and the PERIOD bus packing.

Test Plan:
1. CLK_IN 10 ns, SIG_IN[0] period 40 ns, defaults, START → after 3 skipped and 4 measured edges: PERIOD[0]=4, VALID[0]=1, TIMEOUT[0]=0, one DONE pulse.
2. SIG_IN[1] period 45 ns (measured periods alternate 4/5, total 18) → PERIOD[1]=4 (truncated). SIG_IN[2] period 1000 ns → PERIOD[2]=100.
3. SIG_IN[3] held at 0 for the whole run → TIMEOUT[3]=1 exactly 65535 cycles after START, PERIOD[3]=16'hFFFF, VALID[3]=0. DONE must wait for channel 3.
4. Second START pulse while BUSY=1 → ignored; results identical to a single-START run. START after DONE clears VALID/TIMEOUT and re-measures.
5. RESET asserted mid-COUNT → next cycle BUSY=0, VALID=0, PERIOD=0, no DONE pulse. A following START produces correct results.
6. With CLK_METER_STABLE_EN and TOL=1, run START twice on the 40 ns signal → first run STABLE=0, second run STABLE=1. Change the signal to 60 ns and run a third time → STABLE=0, PERIOD=6.
